// File: rtl/ddu_pkg.sv
// Shared constants for the debug-display-unit controller: blanking values
// and the active-low hex glyph table, bit order {g,f,e,d,c,b,a}.
package ddu_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  function automatic logic [7:0] an_onehot(input logic [2:0] idx);
    an_onehot = ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, consecutive-cycle filter and
// a registered rising-edge pulse that fires on the same edge the level rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_500,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  logic          level_q, rise_q;
  logic [CW-1:0] cnt_q;

  // cnt_q is a down-counter of remaining mismatch cycles; any agreement
  // between the synchronized input and the level reloads it.
  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= CNT_TOP;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= CNT_TOP;
      end else if (cnt_q == '0) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        cnt_q   <= CNT_TOP;
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/ddu_ctrl.sv
// Debug-display-unit controller: gates the CPU clock-enable for free-run or
// single-step, steps the debug address and scans the selected word onto the display.
module ddu_ctrl
  import ddu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SCAN_DIV        = 1024,
  parameter int ADDR_W          = 8
) (
  input  logic              clk_500,
  input  logic              rst_n,
  input  logic              cont,
  input  logic              step,
  input  logic              mem,
  input  logic              inc,
  input  logic              dec,
  input  logic [31:0]       reg_data,
  input  logic [31:0]       mem_data,
  input  logic [31:0]       pc,
  output logic              cpu_run,
  output logic [ADDR_W-1:0] dbg_addr,
  output logic [7:0]        an,
  output logic [6:0]        seg,
  output logic [15:0]       led
);

  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0]     PRE_TC   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     PRE_ONE  = PW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic              cont_s1_q, cont_s2_q, mem_s1_q, mem_s2_q;
  logic              step_lvl, step_rise, inc_lvl, inc_rise, dec_lvl, dec_rise;
  logic              cpu_run_q, cpu_run_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        digit_q, digit_d;
  logic [31:0]       disp_q, disp_d;
  logic [7:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [15:0]       led_q, led_d;
  logic [3:0]        nib;
  logic              unused_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk_500(clk_500), .rst_n(rst_n), .din(step), .level(step_lvl), .rise(step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk_500(clk_500), .rst_n(rst_n), .din(inc), .level(inc_lvl), .rise(inc_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk_500(clk_500), .rst_n(rst_n), .din(dec), .level(dec_lvl), .rise(dec_rise)
  );

  always_comb begin
    cpu_run_d = cont_s2_q | step_rise;

    addr_d = addr_q;
    if (inc_rise && !dec_rise) begin
      addr_d = addr_q + ADDR_ONE;
    end else if (dec_rise && !inc_rise) begin
      addr_d = addr_q - ADDR_ONE;
    end

    pre_d   = pre_q + PRE_ONE;
    digit_d = digit_q;
    disp_d  = disp_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (pre_q == PRE_TC) begin
      pre_d   = '0;
      digit_d = digit_q + 3'd1;
      // Latch a fresh word only at the start of a sweep so digits never mix words.
      if (digit_q == 3'd7) begin
        disp_d = mem_s2_q ? mem_data : reg_data;
      end
    end

    nib = disp_d[{digit_d, 2'b00} +: 4];
    if (pre_q == PRE_TC) begin
      an_d  = an_onehot(digit_d);
      seg_d = HEX_GLYPH[nib];
    end

    led_d = {8'(addr_q), pc[9:2]};
  end

  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      cont_s1_q <= 1'b0;
      cont_s2_q <= 1'b0;
      mem_s1_q  <= 1'b0;
      mem_s2_q  <= 1'b0;
      cpu_run_q <= 1'b0;
      addr_q    <= '0;
      pre_q     <= '0;
      digit_q   <= 3'd7;
      disp_q    <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      led_q     <= '0;
    end else begin
      cont_s1_q <= cont;
      cont_s2_q <= cont_s1_q;
      mem_s1_q  <= mem;
      mem_s2_q  <= mem_s1_q;
      cpu_run_q <= cpu_run_d;
      addr_q    <= addr_d;
      pre_q     <= pre_d;
      digit_q   <= digit_d;
      disp_q    <= disp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      led_q     <= led_d;
    end
  end

  assign unused_ok = ^{pc[31:10], pc[1:0], step_lvl, inc_lvl, dec_lvl};

  assign cpu_run  = cpu_run_q;
  assign dbg_addr = addr_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign led      = led_q;

endmodule
